pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central pipeline sequencing controller for the 5-stage core (PC/IF/ID/EX/MEM/WB).
- Merges stall requests from ID (load-use) and EX (external busy).
- Sequences multi-cycle EX operations (hi/lo multiply-accumulate, divide) by holding the front of the pipe for a programmed cycle count.
- Converts a MEM-stage exception into a registered flush with a redirect PC.
- Feeds the per-stage stall vector and flush to every pipeline register, including EX/MEM, and keeps a stall-cycle performance counter.

Parameters:
CNT_W, 6, width of the multi-cycle length and counter
FLUSH_CYCLES, 1, cycles flush stays asserted per exception (1..3)
ADDR_W, 32, width of exception vector / new_pc

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
stallreq_id  in  1  ID hazard stall request
stallreq_ex  in  1  EX external stall request
mc_start  in  1  EX begins a multi-cycle op this cycle
mc_cycles  in  CNT_W  total cycles the op occupies EX (sampled with mc_start)
excp_req  in  1  exception detected in MEM this cycle
excp_vector  in  ADDR_W  handler address, sampled with excp_req
stall  out  6  per-stage stall: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
flush  out  1  clear all pipeline registers
new_pc  out  ADDR_W  redirect target, valid while flush=1
mc_busy  out  1  multi-cycle op in progress
mc_done  out  1  one-cycle pulse in last cycle of a multi-cycle op
stall_cnt  out  32  cycles with stall!=0, saturating

Behaviour:
- FSM states: RUN, MC, FLUSH. Registers: state, cnt[CNT_W], fcnt, new_pc, stall_cnt.
- Reset, synchronous (rst=1 at clk edge): state=RUN, cnt=0, fcnt=0, new_pc=0, stall_cnt=0. While rst=1, stall=0, flush=0, mc_busy=0, mc_done=0 (combinational override). Reset mid-MC or mid-FLUSH aborts immediately; no mc_done is issued.
- stall, mc_done and mc_busy are combinational from state, cnt and the inputs, with zero latency. flush and new_pc are registered.
- Stall encodings: ID stall = 6'b000111; EX stall = 6'b001111; none = 6'b000000.
- Stall priority: FLUSH state > excp_req > EX stall > ID stall.
- RUN state:
  - excp_req=1: stall=0. Next state FLUSH, new_pc<=excp_vector, fcnt<=FLUSH_CYCLES-1. Any mc_start in the same cycle is ignored.
  - else mc_start=1, mc_cycles=0: no stall; mc_done=1 this cycle; stay in RUN.
  - else mc_start=1, mc_cycles=1: stall=EX; mc_done=1; stay in RUN.
  - else mc_start=1, mc_cycles=N>1: stall=EX; cnt<=N-1; next state MC.
  - else stallreq_ex: stall=EX. Else stallreq_id: stall=ID. Else stall=0.
- MC state:
  - mc_busy=1 and stall=EX, regardless of stallreq_id or stallreq_ex.
  - mc_start is ignored.
  - If cnt==1: mc_done=1, next state RUN. Otherwise cnt<=cnt-1.
  - Total EX-stall cycles for length N = exactly N, starting in the mc_start cycle.
  - excp_req=1 in MC: abort the op with no mc_done; stall=0; go to FLUSH as from RUN.
- FLUSH state:
  - flush=1, stall=0, new_pc held.
  - excp_req, mc_start and stall requests are ignored.
  - If fcnt==0, next state RUN; otherwise fcnt decrements.
  - flush is high for exactly FLUSH_CYCLES cycles, starting the cycle after excp_req.
- In every state other than FLUSH, flush=0 and new_pc retains its last value.
- stall_cnt increments on each non-reset cycle with stall!=0 and saturates at 32'hFFFFFFFF (no wrap).

Test Plan:
- Reset, then idle with all inputs 0 -> stall=0, flush=0, stall_cnt=0; rst asserted in mid-MC (N=10, cycle 4) -> next cycle state RUN, mc_busy=0, no mc_done pulse.
- stallreq_id=1 for 3 cycles with stallreq_ex=1 in the middle cycle -> stall=000111, 001111, 000111; stall_cnt=3.
- mc_start with mc_cycles=5 at cycle 10 -> stall=001111 cycles 10..14; mc_busy=1 cycles 11..14; mc_done=1 only at cycle 14; stall=0 at cycle 15. Repeat with N=1 (stall and mc_done at cycle 10 only) and N=0 (mc_done at cycle 10, no stall).
- excp_req with excp_vector=32'hBFC00380 at cycle 20 during MC (N=8 started at cycle 18), FLUSH_CYCLES=2 -> stall=0 at cycle 20; flush=1 and new_pc=BFC00380 at cycles 21..22; no mc_done; excp_req=1 at cycle 21 ignored; RUN at cycle 23.
- mc_start and excp_req in the same RUN cycle -> FLUSH taken; mc_busy never asserts.
- Force stall_cnt to 32'hFFFFFFFE, then 3 stall cycles -> stall_cnt=FFFFFFFF, holds (no wrap).

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if
// Bundles the pipeline-facing signals of the sequencing controller.
//   master : pipeline side; drives stall/multi-cycle/exception requests and
//            observes the stall vector, flush, redirect PC and status.
//   slave  : controller side (pipe_ctrl).
// Request signals : stallreq_id, stallreq_ex, mc_start, mc_cycles,
//                   excp_req, excp_vector
// Result signals  : stall[5:0], flush, new_pc, mc_busy, mc_done, stall_cnt
// ---------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int CNT_W  = 6,
  parameter int ADDR_W = 32
);
  logic              stallreq_id;
  logic              stallreq_ex;
  logic              mc_start;
  logic [CNT_W-1:0]  mc_cycles;
  logic              excp_req;
  logic [ADDR_W-1:0] excp_vector;
  logic [5:0]        stall;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic              mc_busy;
  logic              mc_done;
  logic [31:0]       stall_cnt;

  modport master (
    output stallreq_id, stallreq_ex, mc_start, mc_cycles, excp_req, excp_vector,
    input  stall, flush, new_pc, mc_busy, mc_done, stall_cnt
  );

  modport slave (
    input  stallreq_id, stallreq_ex, mc_start, mc_cycles, excp_req, excp_vector,
    output stall, flush, new_pc, mc_busy, mc_done, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Central sequencing controller for the 5-stage pipeline.
//   - merges ID (load-use) and EX (external busy) stall requests
//   - holds the front of the pipe for multi-cycle EX operations
//   - turns a MEM exception into a registered flush plus redirect PC
//   - counts stalled cycles (saturating)
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : pipe_ctrl_if.slave (requests in, stall/flush/new_pc/status out)
// Stall vector bits: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int CNT_W        = 6,
  parameter int FLUSH_CYCLES = 1,
  parameter int ADDR_W       = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [1:0] FCNT_INIT  = 2'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MC    = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [1:0]        fcnt_r;
  logic [ADDR_W-1:0] new_pc_r;
  logic              flush_r;
  logic [31:0]       stall_cnt_r;

  logic [5:0]        stall_s;
  logic              mc_done_s;
  logic              mc_busy_s;

  // Zero-latency stall vector and multi-cycle status from state and inputs.
  always_comb begin
    stall_s   = STALL_NONE;
    mc_done_s = 1'b0;
    mc_busy_s = 1'b0;
    if (rst) begin
      stall_s   = STALL_NONE;
      mc_done_s = 1'b0;
      mc_busy_s = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (bus.excp_req) begin
            // exception wins over everything; the faulting op is squashed
            stall_s = STALL_NONE;
          end else if (bus.mc_start) begin
            if (bus.mc_cycles == {CNT_W{1'b0}}) begin
              // zero-length op completes without occupying EX
              stall_s   = STALL_NONE;
              mc_done_s = 1'b1;
            end else if (bus.mc_cycles == CNT_W'(1)) begin
              stall_s   = STALL_EX;
              mc_done_s = 1'b1;
            end else begin
              stall_s   = STALL_EX;
            end
          end else if (bus.stallreq_ex) begin
            stall_s = STALL_EX;
          end else if (bus.stallreq_id) begin
            stall_s = STALL_ID;
          end else begin
            stall_s = STALL_NONE;
          end
        end
        MC: begin
          mc_busy_s = 1'b1;
          if (bus.excp_req) begin
            // abort: no completion pulse
            stall_s = STALL_NONE;
          end else begin
            stall_s   = STALL_EX;
            mc_done_s = (cnt_r == CNT_W'(1));
          end
        end
        FLUSH: begin
          stall_s = STALL_NONE;
        end
        default: begin
          stall_s = STALL_NONE;
        end
      endcase
    end
  end

  // Sequencing FSM with registered flush and redirect PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= RUN;
      cnt_r    <= {CNT_W{1'b0}};
      fcnt_r   <= 2'd0;
      new_pc_r <= {ADDR_W{1'b0}};
      flush_r  <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (bus.excp_req) begin
            state_r  <= FLUSH;
            new_pc_r <= bus.excp_vector;
            fcnt_r   <= FCNT_INIT;
            flush_r  <= 1'b1;
          end else if (bus.mc_start && (bus.mc_cycles > CNT_W'(1))) begin
            // mc_start cycle is the first of N stall cycles, so N-1 remain
            state_r <= MC;
            cnt_r   <= bus.mc_cycles - CNT_W'(1);
          end else begin
            state_r <= RUN;
          end
        end
        MC: begin
          if (bus.excp_req) begin
            state_r  <= FLUSH;
            new_pc_r <= bus.excp_vector;
            fcnt_r   <= FCNT_INIT;
            flush_r  <= 1'b1;
            cnt_r    <= {CNT_W{1'b0}};
          end else if (cnt_r == CNT_W'(1)) begin
            state_r <= RUN;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            cnt_r   <= cnt_r - CNT_W'(1);
          end
        end
        FLUSH: begin
          if (fcnt_r == 2'd0) begin
            state_r <= RUN;
            flush_r <= 1'b0;
          end else begin
            fcnt_r  <= fcnt_r - 2'd1;
          end
        end
        default: begin
          state_r <= RUN;
          flush_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which any stage is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else if ((stall_s != STALL_NONE) && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.stall     = stall_s;
  assign bus.mc_done   = mc_done_s;
  assign bus.mc_busy   = mc_busy_s;
  assign bus.flush     = flush_r & ~rst;
  assign bus.new_pc    = new_pc_r;
  assign bus.stall_cnt = stall_cnt_r;

endmodule
